// File: rtl/cpu_pkg.sv
// Shared decode definitions for the CPU core: opcode encodings, the per-instruction
// control bundle and the opcode class table that fills it.
package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NAND = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_INC  = 4'h4;
    localparam logic [3:0] OP_SRA  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_JAL  = 4'hD;
    localparam logic [3:0] OP_JR   = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef struct packed {
        logic       re0;
        logic       re1;
        logic [3:0] addr0;
        logic [3:0] addr1;
        logic [3:0] dst;
        logic       dstLink;
        logic       we;
        logic       memRd;
        logic       memWr;
        logic       branch;
        logic       jump;
        logic       src1Sel;
        logic       hlt;
    } decCtrl_t;

    // Register fields are returned at full 4-bit width; the stage truncates them.
    function automatic decCtrl_t decodeInstr(input logic [15:0] instr);
        decCtrl_t   c;
        logic [3:0] op;
        op      = instr[15:12];
        c       = '0;
        c.addr0 = instr[7:4];
        c.addr1 = instr[3:0];
        c.dst   = instr[11:8];
        case (op)
            OP_ADD, OP_SUB, OP_NAND, OP_XOR,
            OP_INC, OP_SRA, OP_SRL, OP_SLL: begin
                c.re0 = 1'b1;
                c.re1 = 1'b1;
                c.we  = 1'b1;
            end
            OP_LW: begin
                c.re0     = 1'b1;
                c.we      = 1'b1;
                c.memRd   = 1'b1;
                c.src1Sel = 1'b1;
            end
            OP_SW: begin
                c.re0     = 1'b1;
                c.re1     = 1'b1;
                c.addr1   = instr[11:8];
                c.memWr   = 1'b1;
                c.src1Sel = 1'b1;
            end
            OP_LHB, OP_LLB: begin
                c.re0     = 1'b1;
                c.addr0   = instr[11:8];
                c.we      = 1'b1;
                c.src1Sel = 1'b1;
            end
            OP_B:   c.branch = 1'b1;
            OP_JAL: begin
                c.jump    = 1'b1;
                c.we      = 1'b1;
                c.dstLink = 1'b1;
            end
            OP_JR: begin
                c.re0  = 1'b1;
                c.jump = 1'b1;
            end
            default: c.hlt = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rf_bypass.sv
// Register file with two combinational read ports, one write port, R0 tied to zero
// and write-through bypass so a same-cycle writeback is visible to decode.
module rf_bypass #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rdAddr0,
    input  logic [ADDR_W-1:0] rdAddr1,
    output logic [DATA_W-1:0] rdData0,
    output logic [DATA_W-1:0] rdData1,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData
);

    logic [DATA_W-1:0] regs [NREGS];

    assign rdData0 = (rdAddr0 == '0) ? '0 :
                     (wrEn && (wrAddr == rdAddr0)) ? wrData : regs[rdAddr0];
    assign rdData1 = (rdAddr1 == '0) ? '0 :
                     (wrEn && (wrAddr == rdAddr1)) ? wrData : regs[rdAddr1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn && (wrAddr != '0)) begin
            regs[wrAddr] <= wrData;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: register read with bypass, load-use interlock, flush, sticky halt,
// and the ID/EX pipeline register that carries every decode output to EX.
module id_stage_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NREGS    = 16,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int LINK_REG = NREGS - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] pc_plus1,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_if,
    output logic              id_valid,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] sext,
    output logic [DATA_W-1:0] link_data,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              we,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              branch,
    output logic              jump,
    output logic              src1sel,
    output logic              hlt,
    output logic [2:0]        branch_op,
    output logic [3:0]        alu_op,
    output logic [3:0]        shamt
);

    // Handshake: if_valid qualifies instr/pc_plus1; stall_if=1 means IF must present the
    // same instruction again next cycle; id_valid qualifies every ID/EX output, and
    // ex_stall=1 freezes the whole ID/EX register (writeback still proceeds).

    decCtrl_t          ctrl;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] rdData0, rdData1;
    logic              hazard, loadValid, haltSeen;

    logic [DATA_W-1:0] nP0, nP1, nSext, nLink;
    logic [ADDR_W-1:0] nDst;
    logic              nWe, nMemRd, nMemWr, nBranch, nJump, nSrc1Sel;
    logic [2:0]        nBranchOp;
    logic [3:0]        nAluOp, nShamt;

    assign ctrl  = decodeInstr(instr);
    assign addr0 = ctrl.addr0[ADDR_W-1:0];
    assign addr1 = ctrl.addr1[ADDR_W-1:0];

    rf_bypass #(
        .DATA_W(DATA_W),
        .NREGS (NREGS)
    ) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .rdAddr0(addr0),
        .rdAddr1(addr1),
        .rdData0(rdData0),
        .rdData1(rdData1),
        .wrEn   (wb_we),
        .wrAddr (wb_addr),
        .wrData (wb_data)
    );

    // A load in EX whose result is needed now: insert exactly one bubble.
    assign hazard = id_valid & mem_rd & (dst_addr != '0) & if_valid &
                    ((ctrl.re0 & (addr0 == dst_addr)) | (ctrl.re1 & (addr1 == dst_addr)));

    assign stall_if  = ex_stall | (hazard & ~flush);
    assign loadValid = if_valid & ~flush & ~hazard & ~haltSeen;
    assign hlt       = haltSeen;

    always_comb begin
        nP0       = '0;
        nP1       = '0;
        nSext     = '0;
        nLink     = '0;
        nDst      = '0;
        nWe       = 1'b0;
        nMemRd    = 1'b0;
        nMemWr    = 1'b0;
        nBranch   = 1'b0;
        nJump     = 1'b0;
        nSrc1Sel  = 1'b0;
        nBranchOp = '0;
        nAluOp    = '0;
        nShamt    = '0;
        if (loadValid) begin
            nP0       = ctrl.re0 ? rdData0 : '0;
            nP1       = ctrl.re1 ? rdData1 : '0;
            nSext     = {{(DATA_W-8){instr[7]}}, instr[7:0]};
            nLink     = pc_plus1;
            nDst      = ctrl.dstLink ? ADDR_W'(LINK_REG) : ctrl.dst[ADDR_W-1:0];
            nWe       = ctrl.we;
            nMemRd    = ctrl.memRd;
            nMemWr    = ctrl.memWr;
            nBranch   = ctrl.branch;
            nJump     = ctrl.jump;
            nSrc1Sel  = ctrl.src1Sel;
            nBranchOp = instr[11:9];
            nAluOp    = instr[15:12];
            nShamt    = instr[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid  <= 1'b0;
            p0        <= '0;
            p1        <= '0;
            sext      <= '0;
            link_data <= '0;
            dst_addr  <= '0;
            we        <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            branch    <= 1'b0;
            jump      <= 1'b0;
            src1sel   <= 1'b0;
            branch_op <= '0;
            alu_op    <= '0;
            shamt     <= '0;
            haltSeen  <= 1'b0;
        end else if (!ex_stall) begin
            id_valid  <= loadValid;
            p0        <= nP0;
            p1        <= nP1;
            sext      <= nSext;
            link_data <= nLink;
            dst_addr  <= nDst;
            we        <= nWe;
            mem_rd    <= nMemRd;
            mem_wr    <= nMemWr;
            branch    <= nBranch;
            jump      <= nJump;
            src1sel   <= nSrc1Sel;
            branch_op <= nBranchOp;
            alu_op    <= nAluOp;
            shamt     <= nShamt;
            // Halt is sticky: once a HLT issues, nothing else ever becomes valid.
            if (loadValid && ctrl.hlt) begin
                haltSeen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomized and directed bench for id_stage_pipe, checked against a transaction-level
// model of decode, register state, interlock, flush, stall and halt.
module tb_id_stage_pipe;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, flush, ex_stall, wb_we;
    logic [15:0] instr, pc_plus1, wb_data;
    logic [3:0]  wb_addr;

    logic        stall_if, id_valid, we, mem_rd, mem_wr, branch, jump, src1sel, hlt;
    logic [15:0] p0, p1, sext, link_data;
    logic [3:0]  dst_addr, alu_op, shamt;
    logic [2:0]  branch_op;

    logic        stallIf8, idValid8, we8, memRd8, memWr8, branch8, jump8, src1sel8, hlt8;
    logic [15:0] p0_8, p1_8, sext8, linkData8;
    logic [2:0]  dstAddr8, branchOp8;
    logic [3:0]  aluOp8, shamt8;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(16), .NREGS(16)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instr(instr), .pc_plus1(pc_plus1),
        .flush(flush), .ex_stall(ex_stall), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_if(stall_if), .id_valid(id_valid), .p0(p0), .p1(p1), .sext(sext),
        .link_data(link_data), .dst_addr(dst_addr), .we(we), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .branch(branch), .jump(jump), .src1sel(src1sel), .hlt(hlt), .branch_op(branch_op),
        .alu_op(alu_op), .shamt(shamt)
    );

    id_stage_pipe #(.DATA_W(16), .NREGS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instr(instr), .pc_plus1(pc_plus1),
        .flush(flush), .ex_stall(ex_stall), .wb_we(wb_we), .wb_addr(wb_addr[2:0]), .wb_data(wb_data),
        .stall_if(stallIf8), .id_valid(idValid8), .p0(p0_8), .p1(p1_8), .sext(sext8),
        .link_data(linkData8), .dst_addr(dstAddr8), .we(we8), .mem_rd(memRd8), .mem_wr(memWr8),
        .branch(branch8), .jump(jump8), .src1sel(src1sel8), .hlt(hlt8), .branch_op(branchOp8),
        .alu_op(aluOp8), .shamt(shamt8)
    );

    typedef struct packed {
        logic        valid;
        logic [15:0] p0, p1, sext, link;
        logic [3:0]  dst;
        logic        we, memRd, memWr, branch, jump, src1sel, hlt;
        logic [2:0]  bop;
        logic [3:0]  aop, shamt;
        logic        useA, useB;
    } exp_t;

    exp_t        expQ[$];
    exp_t        cur;
    logic [15:0] mRegs [16];
    bit          mHalt;
    logic        sampStall;
    int          nChecks = 0;
    int          nFails  = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic setIn(input logic iv, input logic [15:0] ins, input logic [15:0] pc,
                         input logic fl, input logic st, input logic wwe,
                         input logic [3:0] wa, input logic [15:0] wd);
        if_valid = iv; instr = ins; pc_plus1 = pc; flush = fl; ex_stall = st;
        wb_we = wwe; wb_addr = wa; wb_data = wd;
    endtask

    function automatic logic [15:0] readModel(input logic [3:0] a);
        if (a == 4'd0) return 16'h0;
        if (wb_we && wb_addr == a) return wb_data;
        return mRegs[a];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mRegs[i] = 16'h0;
        mHalt = 1'b0;
        cur   = '0;
        expQ.delete();
    endtask

    task automatic compareOut(input exp_t e);
        checkVal("id_valid", id_valid, e.valid);
        checkVal("we", we, e.we);
        checkVal("mem_rd", mem_rd, e.memRd);
        checkVal("mem_wr", mem_wr, e.memWr);
        checkVal("branch", branch, e.branch);
        checkVal("jump", jump, e.jump);
        checkVal("src1sel", src1sel, e.src1sel);
        checkVal("hlt", hlt, e.hlt);
        checkVal("alu_op", alu_op, e.aop);
        checkVal("shamt", shamt, e.shamt);
        checkVal("sext", sext, e.sext);
        if (!e.valid || e.useA)   checkVal("p0", p0, e.p0);
        if (!e.valid || e.useB)   checkVal("p1", p1, e.p1);
        if (!e.valid || e.we)     checkVal("dst_addr", dst_addr, e.dst);
        if (!e.valid || e.jump)   checkVal("link_data", link_data, e.link);
        if (!e.valid || e.branch) checkVal("branch_op", branch_op, e.bop);
    endtask

    // Called with inputs already driven just after a rising edge; ends 1 time unit after the next one.
    task automatic step();
        logic [3:0] op, rd, rs, rt, a, b;
        bit         useA, useB, hz;
        exp_t       nx;
        #1;
        op = instr[15:12]; rd = instr[11:8]; rs = instr[7:4]; rt = instr[3:0];
        useA = 0; useB = 0; a = rs; b = rt;
        case (op)
            4'h8, 4'hE: useA = 1;
            4'h9: begin useA = 1; useB = 1; b = rd; end
            4'hA, 4'hB: begin useA = 1; a = rd; end
            4'hC, 4'hD, 4'hF: ;
            default: begin useA = 1; useB = 1; end
        endcase
        hz = if_valid && cur.valid && cur.memRd && cur.dst != 0 &&
             ((useA && a == cur.dst) || (useB && b == cur.dst));
        sampStall = stall_if;
        checkVal("stall_if", stall_if, ex_stall || (hz && !flush));
        if (ex_stall) begin
            nx = cur;
        end else if (!if_valid || flush || hz || mHalt) begin
            nx = '0;
            nx.hlt = mHalt;
        end else begin
            nx = '0;
            nx.valid   = 1;
            nx.useA    = useA;
            nx.useB    = useB;
            nx.p0      = useA ? readModel(a) : 16'h0;
            nx.p1      = useB ? readModel(b) : 16'h0;
            nx.sext    = {{8{instr[7]}}, instr[7:0]};
            nx.link    = pc_plus1;
            nx.dst     = (op == 4'hD) ? 4'd15 : rd;
            nx.we      = (op <= 4'hB && op != 4'h9) || op == 4'hD;
            nx.memRd   = (op == 4'h8);
            nx.memWr   = (op == 4'h9);
            nx.branch  = (op == 4'hC);
            nx.jump    = (op == 4'hD) || (op == 4'hE);
            nx.src1sel = op inside {4'h8, 4'h9, 4'hA, 4'hB};
            nx.hlt     = (op == 4'hF);
            nx.bop     = instr[11:9];
            nx.aop     = op;
            nx.shamt   = rt;
            if (op == 4'hF) mHalt = 1'b1;
        end
        if (wb_we && wb_addr != 0) mRegs[wb_addr] = wb_data;
        expQ.push_back(nx);
        @(posedge clk);
        #1;
        cur = expQ.pop_front();
        compareOut(cur);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] op;
        setIn(0, 16'h0, 16'h0, 0, 0, 0, 4'd0, 16'h0);
        rst_n = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_id_valid", id_valid, 0);
        checkVal("rst_hlt", hlt, 0);
        checkVal("rst_stall_if", stall_if, 0);
        rst_n = 1'b1;

        // Bypass: writeback to R5 in the same cycle ADD R1,R5,R5 decodes.
        setIn(1, {OP_ADD, 4'd1, 4'd5, 4'd5}, 16'h0010, 0, 0, 1, 4'd5, 16'h1234);
        step();
        checkVal("byp_p0", p0, 16'h1234);
        checkVal("byp_p1", p1, 16'h1234);
        checkVal("byp_we", we, 1);
        checkVal("byp_dst", dst_addr, 4'd1);

        // Mid-stream asynchronous reset with a valid instruction in ID/EX.
        setIn(1, {OP_SUB, 4'd6, 4'd5, 4'd1}, 16'h0011, 0, 0, 1, 4'd3, 16'h5555);
        step();
        checkVal("pre_rst_valid", id_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        checkVal("arst_id_valid", id_valid, 0);
        checkVal("arst_we", we, 0);
        checkVal("arst_p0", p0, 0);
        checkVal("arst_dst", dst_addr, 0);
        checkVal("arst_alu_op", alu_op, 0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        setIn(1, {OP_ADD, 4'd1, 4'd3, 4'd3}, 16'h0001, 0, 0, 0, 4'd0, 16'h0);
        step();
        checkVal("rst_r3_p0", p0, 16'h0);

        // Load-use: exactly one bubble, then the consumer issues.
        setIn(1, {OP_LW, 4'd2, 4'd4, 4'd0}, 16'h0002, 0, 0, 0, 4'd0, 16'h0);
        step();
        setIn(1, {OP_ADD, 4'd3, 4'd2, 4'd1}, 16'h0003, 0, 0, 0, 4'd0, 16'h0);
        step();
        checkVal("lu_stall", sampStall, 1);
        checkVal("lu_bubble", id_valid, 0);
        step();
        checkVal("lu_stall_gone", sampStall, 0);
        checkVal("lu_issue", id_valid, 1);
        checkVal("lu_issue_dst", dst_addr, 4'd3);
        setIn(1, {OP_LW, 4'd0, 4'd4, 4'd0}, 16'h0004, 0, 0, 0, 4'd0, 16'h0);
        step();
        setIn(1, {OP_ADD, 4'd3, 4'd0, 4'd1}, 16'h0005, 0, 0, 0, 4'd0, 16'h0);
        step();
        checkVal("lu_r0_nostall", sampStall, 0);
        checkVal("lu_r0_valid", id_valid, 1);

        // Flush with hazard, then ex_stall holding the register for 3 cycles.
        setIn(1, {OP_LW, 4'd2, 4'd4, 4'd0}, 16'h0006, 0, 0, 0, 4'd0, 16'h0);
        step();
        setIn(1, {OP_ADD, 4'd3, 4'd2, 4'd1}, 16'h0007, 1, 0, 0, 4'd0, 16'h0);
        step();
        checkVal("fl_hz_stall", sampStall, 0);
        checkVal("fl_hz_bubble", id_valid, 0);
        setIn(1, {OP_ADD, 4'd1, 4'd5, 4'd5}, 16'h0008, 0, 0, 1, 4'd5, 16'h4321);
        step();
        for (int i = 0; i < 3; i++) begin
            setIn(1, {OP_SW, 4'd7, 4'd8, 4'd9}, 16'h0009, 0, 1, 0, 4'd0, 16'h0);
            step();
            checkVal("exs_stall", sampStall, 1);
            checkVal("exs_valid", id_valid, 1);
            checkVal("exs_dst", dst_addr, 4'd1);
            checkVal("exs_p0", p0, 16'h4321);
        end

        // JAL link register in both register-file sizes.
        setIn(1, {OP_JAL, 4'd0, 4'd0, 4'd0}, 16'h0042, 0, 0, 0, 4'd0, 16'h0);
        step();
        checkVal("jal_jump", jump, 1);
        checkVal("jal_we", we, 1);
        checkVal("jal_dst", dst_addr, 4'd15);
        checkVal("jal_link", link_data, 16'h0042);
        checkVal("jal8_valid", idValid8, 1);
        checkVal("jal8_dst", dstAddr8, 3'd7);
        checkVal("jal8_jump", jump8, 1);
        checkVal("jal8_link", linkData8, 16'h0042);

        // Randomized traffic; IF holds its instruction while stall_if is high.
        for (int i = 0; i < 400; i++) begin
            if (!sampStall) begin
                op = (($urandom_range(0, 3) == 0) ? OP_LW : 4'($urandom_range(0, 14)));
                instr    = {op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                            4'($urandom_range(0, 15))};
                pc_plus1 = 16'($urandom);
            end
            if_valid = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            ex_stall = ($urandom_range(0, 6) == 0);
            wb_we    = 1'($urandom_range(0, 1));
            wb_addr  = 4'($urandom_range(0, 7));
            wb_data  = 16'($urandom);
            step();
        end

        // Sticky halt, cleared only by reset.
        setIn(1, {OP_HLT, 4'd0, 4'd0, 4'd0}, 16'h0100, 0, 0, 0, 4'd0, 16'h0);
        step();
        checkVal("hlt_valid", id_valid, 1);
        checkVal("hlt_set", hlt, 1);
        setIn(1, {OP_ADD, 4'd1, 4'd2, 4'd3}, 16'h0101, 0, 0, 0, 4'd0, 16'h0);
        step();
        checkVal("hlt_add_valid", id_valid, 0);
        checkVal("hlt_add_we", we, 0);
        checkVal("hlt_sticky", hlt, 1);
        for (int i = 0; i < 4; i++) begin
            setIn(1, {OP_LW, 4'($urandom_range(1, 7)), 4'd1, 4'd0}, 16'h0102, 0, 0, 0, 4'd0, 16'h0);
            step();
        end
        checkVal("hlt_still", hlt, 1);
        doReset();
        checkVal("hlt_cleared", hlt, 0);
        setIn(1, {OP_ADD, 4'd1, 4'd2, 4'd3}, 16'h0103, 0, 0, 0, 4'd0, 16'h0);
        step();
        checkVal("post_hlt_valid", id_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
